change_dispenser: RTL and testbench
===================================

Name: change_dispenser

Overview:
Coin-change payout engine on the refund side of the AutoVendor vending machine. It accepts a refund amount from the vendor core and drives a coin hopper, ejecting one coin per handshake until the amount is paid. Denominations are 50, 10, 5 and 1, selected largest-first. Empty tubes fall back to smaller coins, and the block reports a fault when the amount cannot be paid.

Parameters:
COIN_W, 7, width of the amount and value buses (matches AutoVendor refund/total_coin)
ACK_TIMEOUT, 15, maximum cycles eject may stay high without eject_ack before a fault is raised

Ports:
clk  in  1  system clock; all logic is on the rising edge
reset  in  1  synchronous, active-high reset
refund  in  COIN_W  amount to pay out; sampled only when refund_valid is high
refund_valid  in  1  one-cycle start strobe from the vendor core
hopper_empty  in  4  per-tube empty flags: bit3=50, bit2=10, bit1=5, bit0=1
eject_ack  in  1  hopper confirms the requested coin has dropped
eject  out  1  coin-eject request; held high until ack or timeout
eject_sel  out  4  one-hot tube select, same bit order as hopper_empty; valid while eject=1
eject_value  out  COIN_W  value of the coin being ejected (50/10/5/1); 0 when eject=0
remaining  out  COIN_W  amount still owed
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle completion pulse; asserted on success and on fault
fault  out  1  sticky error flag; cleared by reset or by the next accepted refund_valid

Behaviour:
- Reset (synchronous): state=IDLE. eject, eject_sel, eject_value, remaining, busy, done and fault are all 0. The ack timer is cleared.
- States: IDLE, SELECT, EJECT, DONE. All outputs are registered.
- IDLE:
  - refund_valid with refund!=0: latch remaining=refund, clear fault, go to SELECT.
  - refund_valid with refund==0: go to DONE (done pulses; eject is never raised).
- refund_valid while busy=1: ignored. No queueing.
- SELECT (1 cycle): choose the largest d in {50,10,5,1} with d<=remaining and hopper_empty[d]=0.
  - Found: load eject_sel and eject_value, clear the timer, go to EJECT.
  - None found: set fault=1, go to DONE. remaining keeps the unpaid amount.
- Latency: with refund_valid sampled at edge N, eject is high after edge N+2.
- EJECT: eject=1; the timer increments each cycle.
  - eject_ack=1: remaining<=remaining-eject_value, and eject, eject_sel and eject_value drop at the same edge. If the new remaining is 0, go to DONE; otherwise go to SELECT. This gives a minimum of 2 cycles between consecutive ejects.
  - No ack and timer reaches ACK_TIMEOUT-1: fault=1, eject drops, remaining is unchanged, go to DONE.
  - ack and timeout in the same cycle: the ack wins.
- DONE: done=1 for exactly one cycle, then IDLE.
- eject_ack outside EJECT is ignored.
- hopper_empty is sampled only in SELECT. A tube emptying during EJECT does not abort the ejection in progress.
- Arithmetic: the subtraction cannot underflow because d<=remaining is guaranteed by SELECT. Maximum refund is 127, paid as 50,50,10,10,5,1,1 (7 coins).
- Reset during EJECT: eject is 0 at the next edge and the in-flight coin is not counted.

Test Plan:
- refund=6, all tubes full, immediate acks -> eject_value sequence 5 then 1; remaining goes 6→1→0; done pulses once; fault=0; first eject after 2 edges.
- refund=65 -> 50, 10, 5; refund=127 -> 50,50,10,10,5,1,1; done after the last ack.
- hopper_empty=4'b0100 (10-tube empty), refund=20 -> four 5-coin ejects; eject_sel=4'b0010 each time.
- hopper_empty=4'b1111, refund=3 -> no eject; fault=1, done pulses, remaining=3. Next refund_valid clears fault.
- refund=10, eject_ack withheld -> eject high for exactly ACK_TIMEOUT cycles; fault=1, remaining=10. Separately: refund=0 -> done pulse with no eject.
- reset asserted mid-EJECT while refund=50 -> next cycle all outputs 0 and state IDLE. A refund_valid pulsed while busy is ignored (remaining unchanged).

Source files
------------

// File: rtl/change_dispenser_if.sv
// Refund/hopper bundle for the change dispenser. The master side is the
// dispenser: it receives the refund request and hopper status and drives the eject request.
interface change_dispenser_if #(
  parameter int COIN_W = 7
);
  logic [COIN_W-1:0] refund;
  logic              refund_valid;
  logic [3:0]        hopper_empty;
  logic              eject_ack;
  logic              eject;
  logic [3:0]        eject_sel;
  logic [COIN_W-1:0] eject_value;
  logic [COIN_W-1:0] remaining;
  logic              busy;
  logic              done;
  logic              fault;

  modport master (
    input  refund, refund_valid, hopper_empty, eject_ack,
    output eject, eject_sel, eject_value, remaining, busy, done, fault
  );

  modport slave (
    output refund, refund_valid, hopper_empty, eject_ack,
    input  eject, eject_sel, eject_value, remaining, busy, done, fault
  );
endinterface

// File: rtl/change_dispenser.sv
// Coin-change payout engine: pays a refund largest-coin-first (50/10/5/1)
// through a handshaked hopper, skipping empty tubes and flagging unpayable amounts.
module change_dispenser #(
  parameter int COIN_W      = 7,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               reset,
  change_dispenser_if.master bus
);

  typedef enum logic [1:0] {IDLE, SELECT, EJECT, DONE} state_e;

  localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(ACK_TIMEOUT - 1);
  // Index matches hopper_empty / eject_sel bit order.
  localparam logic [COIN_W-1:0] DEN [4] = '{COIN_W'(1), COIN_W'(5), COIN_W'(10), COIN_W'(50)};

  state_e            state_q, state_d;
  logic              req_vld_q, req_vld_d;
  logic [COIN_W-1:0] req_amt_q, req_amt_d;
  logic [COIN_W-1:0] rem_q, rem_d;
  logic              eject_q, eject_d;
  logic [3:0]        sel_q, sel_d;
  logic [COIN_W-1:0] val_q, val_d;
  logic              fault_q, fault_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;

  logic              pick_found;
  logic [3:0]        pick_sel;
  logic [COIN_W-1:0] pick_val;

  // Largest coin that still fits the amount owed and whose tube has coins.
  always_comb begin
    pick_found = 1'b0;
    pick_sel   = '0;
    pick_val   = '0;
    for (int i = 3; i >= 0; i--) begin
      if (!pick_found && !bus.hopper_empty[i] && (rem_q >= DEN[i])) begin
        pick_found  = 1'b1;
        pick_sel[i] = 1'b1;
        pick_val    = DEN[i];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    eject_d   = eject_q;
    sel_d     = sel_q;
    val_d     = val_q;
    fault_d   = fault_q;
    tmr_d     = tmr_q;
    // Requests are staged one cycle; only taken while idle with nothing pending.
    req_vld_d = bus.refund_valid && (state_q == IDLE) && !req_vld_q;
    req_amt_d = req_vld_d ? bus.refund : req_amt_q;

    unique case (state_q)
      IDLE: begin
        if (req_vld_q) begin
          fault_d = 1'b0;
          rem_d   = req_amt_q;
          state_d = (req_amt_q != '0) ? SELECT : DONE;
        end
      end
      SELECT: begin
        if (pick_found) begin
          eject_d = 1'b1;
          sel_d   = pick_sel;
          val_d   = pick_val;
          tmr_d   = '0;
          state_d = EJECT;
        end else begin
          fault_d = 1'b1;
          state_d = DONE;
        end
      end
      EJECT: begin
        if (bus.eject_ack) begin
          rem_d   = rem_q - val_q;
          eject_d = 1'b0;
          sel_d   = '0;
          val_d   = '0;
          state_d = (rem_d == '0) ? DONE : SELECT;
        end else if (tmr_q == TMR_MAX) begin
          fault_d = 1'b1;
          eject_d = 1'b0;
          sel_d   = '0;
          val_d   = '0;
          state_d = DONE;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    done_d = (state_d == DONE);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      req_vld_q <= 1'b0;
      req_amt_q <= '0;
      rem_q     <= '0;
      eject_q   <= 1'b0;
      sel_q     <= '0;
      val_q     <= '0;
      fault_q   <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      tmr_q     <= '0;
    end else begin
      state_q   <= state_d;
      req_vld_q <= req_vld_d;
      req_amt_q <= req_amt_d;
      rem_q     <= rem_d;
      eject_q   <= eject_d;
      sel_q     <= sel_d;
      val_q     <= val_d;
      fault_q   <= fault_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      tmr_q     <= tmr_d;
    end
  end

  assign bus.eject       = eject_q;
  assign bus.eject_sel   = sel_q;
  assign bus.eject_value = val_q;
  assign bus.remaining   = rem_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.fault       = fault_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: drives refunds with randomized hopper ack delays
// and compares payouts against a greedy coin-change model.
module tb_change_dispenser;
  localparam int COIN_W      = 7;
  localparam int ACK_TIMEOUT = 15;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  change_dispenser_if #(.COIN_W(COIN_W)) bus();
  change_dispenser #(.COIN_W(COIN_W), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  int den [4] = '{1, 5, 10, 50};
  int exp_q[$];
  int exp_rem;
  int exp_fault;

  int got_val[$];
  int got_sel[$];
  int got_rem[$];
  int first_ej, eject_cyc, done_cnt, fault_at_done, rem_at_done;

  // Greedy payout as described in words: largest coin that fits and is stocked.
  function automatic void model(input int amt, input logic [3:0] emp);
    int r;
    bit found;
    exp_q.delete();
    r = amt;
    while (r > 0) begin
      found = 0;
      for (int i = 3; i >= 0; i--) begin
        if (!found && !emp[i] && den[i] <= r) begin
          exp_q.push_back(den[i]);
          r -= den[i];
          found = 1;
        end
      end
      if (!found) break;
    end
    exp_rem   = r;
    exp_fault = (r != 0) ? 1 : 0;
  endfunction

  function automatic int sel_of(input int v);
    case (v)
      50: return 8;
      10: return 4;
      5:  return 2;
      1:  return 1;
      default: return 0;
    endcase
  endfunction

  task automatic run_refund(input int amt, input logic [3:0] emp, input bit ack_en, input bit poke);
    int cyc, dly, tail;
    bit poking;
    got_val.delete(); got_sel.delete(); got_rem.delete();
    first_ej = -1; eject_cyc = 0; done_cnt = 0; fault_at_done = -1; rem_at_done = -1;
    dly = $urandom_range(0, 4);
    tail = 0; poking = 0;
    @(negedge clk);
    bus.hopper_empty = emp;
    bus.refund = COIN_W'(amt);
    bus.refund_valid = 1'b1;
    cyc = 0;
    while (cyc < 600 && tail < 6) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) bus.refund_valid = 1'b0;
      if (poking) begin bus.refund_valid = 1'b0; poking = 0; end
      if (bus.done) begin
        done_cnt++;
        fault_at_done = bus.fault;
        rem_at_done = bus.remaining;
      end
      if (bus.eject_ack) begin
        bus.eject_ack = 1'b0;
      end else if (bus.eject) begin
        eject_cyc++;
        if (first_ej < 0) begin
          first_ej = cyc;
          if (poke) begin bus.refund = 7'd99; bus.refund_valid = 1'b1; poking = 1; end
        end
        if (ack_en && dly == 0) begin
          got_val.push_back(int'(bus.eject_value));
          got_sel.push_back(int'(bus.eject_sel));
          got_rem.push_back(int'(bus.remaining));
          bus.eject_ack = 1'b1;
          dly = $urandom_range(0, 4);
        end else if (dly > 0) begin
          dly--;
        end
      end
      if (done_cnt > 0) tail++;
    end
    bus.eject_ack = 1'b0;
    bus.refund_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({bus.eject, bus.eject_sel, bus.eject_value, bus.remaining, bus.busy, bus.done, bus.fault} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got ej=%b sel=%b val=%0d rem=%0d busy=%b done=%b fault=%b want all 0",
               bus.eject, bus.eject_sel, bus.eject_value, bus.remaining, bus.busy, bus.done, bus.fault);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_small();
    run_refund(6, 4'b0000, 1, 0);
    n_cmp++; if (first_ej !== 3) begin n_err++; $display("FAIL latency6: got cycle %0d want 3", first_ej); end
    n_cmp++;
    if (got_val.size() != 2 || got_val[0] != 5 || got_val[1] != 1 || got_sel[0] != 2 || got_sel[1] != 1) begin
      n_err++; $display("FAIL coins6: got val=%p sel=%p want val 5,1 sel 2,1", got_val, got_sel);
    end
    n_cmp++;
    if (got_rem.size() != 2 || got_rem[0] != 6 || got_rem[1] != 1) begin
      n_err++; $display("FAIL rem6: got %p want 6,1", got_rem);
    end
    n_cmp++;
    if (done_cnt != 1 || fault_at_done != 0 || rem_at_done != 0) begin
      n_err++; $display("FAIL done6: got done=%0d fault=%0d rem=%0d want 1,0,0", done_cnt, fault_at_done, rem_at_done);
    end
  endtask

  task automatic test_large();
    int amts [2] = '{65, 127};
    int nexp [2] = '{3, 7};
    bit ok;
    foreach (amts[k]) begin
      run_refund(amts[k], 4'b0000, 1, 0);
      model(amts[k], 4'b0000);
      ok = (got_val.size() == exp_q.size()) && (exp_q.size() == nexp[k]);
      foreach (exp_q[i]) if (ok && got_val[i] != exp_q[i]) ok = 0;
      n_cmp++;
      if (!ok) begin n_err++; $display("FAIL coins%0d: got %p want %p", amts[k], got_val, exp_q); end
      n_cmp++;
      if (done_cnt != 1 || fault_at_done != 0 || rem_at_done != 0) begin
        n_err++; $display("FAIL done%0d: got done=%0d fault=%0d rem=%0d want 1,0,0", amts[k], done_cnt, fault_at_done, rem_at_done);
      end
    end
  endtask

  task automatic test_fallback();
    bit ok;
    run_refund(20, 4'b0100, 1, 0);
    ok = (got_val.size() == 4);
    foreach (got_val[i]) if (got_val[i] != 5 || got_sel[i] != 2) ok = 0;
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL fallback20: got val=%p sel=%p want four 5s on sel 2", got_val, got_sel); end
    n_cmp++;
    if (done_cnt != 1 || fault_at_done != 0) begin
      n_err++; $display("FAIL fallback_done: got done=%0d fault=%0d want 1,0", done_cnt, fault_at_done);
    end
  endtask

  task automatic test_all_empty();
    run_refund(3, 4'b1111, 1, 0);
    n_cmp++;
    if (eject_cyc != 0 || done_cnt != 1 || fault_at_done != 1 || rem_at_done != 3) begin
      n_err++; $display("FAIL empty3: got ej_cyc=%0d done=%0d fault=%0d rem=%0d want 0,1,1,3",
                        eject_cyc, done_cnt, fault_at_done, rem_at_done);
    end
    n_cmp++;
    if (bus.fault !== 1'b1 || bus.busy !== 1'b0) begin
      n_err++; $display("FAIL fault_sticky: got fault=%b busy=%b want 1,0", bus.fault, bus.busy);
    end
    run_refund(1, 4'b0000, 1, 0);
    n_cmp++;
    if (fault_at_done != 0 || got_val.size() != 1 || rem_at_done != 0) begin
      n_err++; $display("FAIL fault_clear: got fault=%0d ncoins=%0d rem=%0d want 0,1,0", fault_at_done, got_val.size(), rem_at_done);
    end
  endtask

  task automatic test_timeout();
    run_refund(10, 4'b0000, 0, 0);
    n_cmp++;
    if (eject_cyc != ACK_TIMEOUT) begin n_err++; $display("FAIL timeout_len: got %0d want %0d", eject_cyc, ACK_TIMEOUT); end
    n_cmp++;
    if (done_cnt != 1 || fault_at_done != 1 || rem_at_done != 10 || bus.eject !== 1'b0) begin
      n_err++; $display("FAIL timeout_end: got done=%0d fault=%0d rem=%0d ej=%b want 1,1,10,0",
                        done_cnt, fault_at_done, rem_at_done, bus.eject);
    end
  endtask

  task automatic test_zero();
    run_refund(0, 4'b0000, 1, 0);
    n_cmp++;
    if (eject_cyc != 0 || done_cnt != 1 || fault_at_done != 0) begin
      n_err++; $display("FAIL zero: got ej_cyc=%0d done=%0d fault=%0d want 0,1,0", eject_cyc, done_cnt, fault_at_done);
    end
  endtask

  task automatic test_busy_ignored();
    bit ok;
    run_refund(65, 4'b0000, 1, 1);
    model(65, 4'b0000);
    ok = (got_val.size() == exp_q.size());
    foreach (exp_q[i]) if (ok && (got_val[i] != exp_q[i] || got_rem[i] != 65 - (i > 0 ? 50 : 0) - (i > 1 ? 10 : 0))) ok = 0;
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL busy_poke: got val=%p rem=%p want val %p", got_val, got_rem, exp_q); end
    n_cmp++;
    if (done_cnt != 1 || bus.busy !== 1'b0) begin
      n_err++; $display("FAIL busy_poke_done: got done=%0d busy=%b want 1,0", done_cnt, bus.busy);
    end
  endtask

  task automatic test_reset_mid();
    int w;
    @(negedge clk);
    bus.hopper_empty = 4'b0000;
    bus.refund = 7'd50;
    bus.refund_valid = 1'b1;
    @(negedge clk);
    bus.refund_valid = 1'b0;
    w = 0;
    while (!bus.eject && w < 10) begin @(negedge clk); w++; end
    n_cmp++;
    if (bus.eject !== 1'b1 || bus.eject_value !== 7'd50) begin
      n_err++; $display("FAIL mid_start: got ej=%b val=%0d want 1,50", bus.eject, bus.eject_value);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({bus.eject, bus.eject_sel, bus.eject_value, bus.remaining, bus.busy, bus.done, bus.fault} !== '0) begin
      n_err++; $display("FAIL mid_reset: got ej=%b sel=%b val=%0d rem=%0d busy=%b done=%b fault=%b want all 0",
                        bus.eject, bus.eject_sel, bus.eject_value, bus.remaining, bus.busy, bus.done, bus.fault);
    end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.eject !== 1'b0) begin
      n_err++; $display("FAIL mid_idle: got busy=%b ej=%b want 0,0", bus.busy, bus.eject);
    end
  endtask

  task automatic test_random();
    int amt;
    logic [3:0] emp;
    bit ok;
    int r;
    for (int k = 0; k < 25; k++) begin
      amt = $urandom_range(0, 127);
      emp = 4'($urandom_range(0, 15));
      if (k < 8) emp = 4'b0000;
      run_refund(amt, emp, 1, 0);
      model(amt, emp);
      ok = (got_val.size() == exp_q.size());
      r = amt;
      foreach (exp_q[i]) begin
        if (ok && (got_val[i] != exp_q[i] || got_sel[i] != sel_of(exp_q[i]) || got_rem[i] != r)) ok = 0;
        r -= exp_q[i];
      end
      n_cmp++;
      if (!ok) begin n_err++; $display("FAIL rand_coins amt=%0d emp=%b: got val=%p sel=%p rem=%p want %p", amt, emp, got_val, got_sel, got_rem, exp_q); end
      n_cmp++;
      if (done_cnt != 1 || fault_at_done != exp_fault || rem_at_done != exp_rem) begin
        n_err++; $display("FAIL rand_done amt=%0d emp=%b: got done=%0d fault=%0d rem=%0d want 1,%0d,%0d",
                          amt, emp, done_cnt, fault_at_done, rem_at_done, exp_fault, exp_rem);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.refund = '0;
    bus.refund_valid = 1'b0;
    bus.hopper_empty = 4'b0000;
    bus.eject_ack = 1'b0;
    test_reset();
    test_small();
    test_large();
    test_fallback();
    test_all_empty();
    test_timeout();
    test_zero();
    test_busy_ignored();
    test_reset_mid();
    test_small();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
